rgb_window_gen: RTL and testbench
=================================

RGB_WINDOW_GEN -- requirements
Module: rgb_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 32, meaning pixels per image line (legal range 3..1024).
REQ-002 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pix_valid_i  input  1  input pixel valid.
REQ-005 SHALL have port pix_ready_o  output  1  input pixel ready.
REQ-006 SHALL have port sof_i  input  1  start of frame; qualified by pixel accept.
REQ-007 SHALL have ports r_i, g_i, b_i  input  8 each  raster-order pixel channels.
REQ-008 SHALL have port win_valid_o  output  1  window valid.
REQ-009 SHALL have port win_ready_i  input  1  window consumer ready.
REQ-010 SHALL have ports r_o, g_o, b_o  output  [2:0][2:0][7:0] each  3x3 window; [x][y], x=0 oldest row, x=2 newest row, y=0 oldest column, y=2 newest column.
REQ-011 SHALL have port err_o  output  1  sticky line-length error (see Configuration).

Function
REQ-012 Pixel accept SHALL occur in a cycle where pix_valid_i && pix_ready_o.
REQ-013 pix_ready_o SHALL equal win_ready_i || !win_valid_o (single-entry output register; one-entry skid is not provided).
REQ-014 Window transfer SHALL occur in a cycle where win_valid_o && win_ready_i; r_o/g_o/b_o SHALL hold stable while win_valid_o && !win_ready_i.
REQ-015 Column counter col_q SHALL count 0..IMG_W-1 per accept and wrap to 0; on wrap, row counter row_q SHALL increment, saturating at 2.
REQ-016 Accept with sof_i=1 SHALL treat that pixel as (row 0, col 0); counters then proceed from there.
REQ-017 Two line buffers (IMG_W x 24 bit each) SHALL hold the two previous lines; on accept at column c, the new window column SHALL be {line-2[c], line-1[c], pixel} and line buffers SHALL shift line-1[c]->line-2[c], pixel->line-1[c].
REQ-018 Window column shift register SHALL shift on every accept (column 0 oldest, column 2 newest).
REQ-019 An accept at row_q>=2 and col_q>=2 (values before update) SHALL produce a window centred at (row-1, col-1); win_valid_o SHALL assert on the next clock edge (latency 1 cycle).
REQ-020 Accepts at row<2 or col<2 SHALL NOT produce a window; windows never straddle a line boundary.
REQ-021 A frame of H lines SHALL yield exactly (IMG_W-2)*(H-2) windows.
REQ-022 Simultaneous transfer and producing accept in one cycle SHALL load the new window; throughput 1 window/cycle.
REQ-023 win_valid_o SHALL clear after transfer when no producing accept occurs in that cycle.

Reset
REQ-024 rst_ni low SHALL asynchronously force win_valid_o=0, pix_ready_o=0, r_o/g_o/b_o=0, err_o=0, col_q=0, row_q=0, window shift registers=0.
REQ-025 Line buffer contents SHALL NOT be reset; their stale data SHALL never reach a valid window due to REQ-019.
REQ-026 From the first clock edge after rst_ni rises, pix_ready_o SHALL be 1; reset mid-frame discards the partial frame and the pending window.

Configuration
REQ-027 Macro RGB_WIN_ERR_EN defined: err_o SHALL set on an accept with sof_i=1 while col_q!=0 or row_q!=0 with col_q!=0 ... i.e. sof_i at col_q!=0 (short line), and SHALL remain 1 until reset.
REQ-028 Macro RGB_WIN_ERR_EN undefined: err_o SHALL be tied 0 and no error logic SHALL be synthesised.

Verification
REQ-029 IMG_W=4, 4x4 frame, r=g=b=4*row+col, win_ready_i=1 -> first window after 11th accept, r_o={{0,1,2},{4,5,6},{8,9,10}}; exactly 4 windows, last {{5,6,7},{9,10,11},{13,14,15}}.
REQ-030 Pending window with win_ready_i=0 for 5 cycles -> pix_ready_o=0, r_o unchanged; win_ready_i=1 -> transfer, pix_ready_o=1 next cycle.
REQ-031 IMG_W=4, sof_i after 6 accepts -> no window until 11th accept after that sof.
REQ-032 rst_ni low mid-frame with win_valid_o=1 -> win_valid_o=0 and r_o=0 without clock edge.
REQ-033 RGB_WIN_ERR_EN defined, sof_i at col_q=2 -> err_o=1 next cycle, held through further frames until reset; undefined -> err_o=0.
REQ-034 IMG_W=5, continuous pix_valid_i and win_ready_i=1 on rows>=2 -> 3 consecutive windows per line, one per cycle, no bubbles.

Source files
------------

// File: rtl/rgb_window_gen.sv
// rgb_window_gen: streaming 3x3 RGB window generator for raster-order pixels.
//
// Ports
//   clk_i, rst_ni                 clock (rising edge) and async active-low reset
//   pix_valid_i / pix_ready_o     input pixel handshake
//   sof_i                         start of frame, qualified by pixel accept
//   r_i, g_i, b_i                 8-bit pixel channels
//   win_valid_o / win_ready_i     output window handshake
//   r_o, g_o, b_o                 3x3 window, [x][y]: x=0 oldest row, y=0 oldest column
//   err_o                         sticky short-line error
//
// Parameter IMG_W: pixels per line (3..1024).
// Optional feature: define RGB_WIN_ERR_EN to build the short-line detector;
// otherwise err_o is tied low.
module rgb_window_gen #(
   parameter int IMG_W = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 pix_valid_i,
   output logic                 pix_ready_o,
   input  logic                 sof_i,
   input  logic [7:0]           r_i,
   input  logic [7:0]           g_i,
   input  logic [7:0]           b_i,
   output logic                 win_valid_o,
   input  logic                 win_ready_i,
   output logic [2:0][2:0][7:0] r_o,
   output logic [2:0][2:0][7:0] g_o,
   output logic [2:0][2:0][7:0] b_o,
   output logic                 err_o
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   typedef logic [CW-1:0] col_t;

   logic             rdy_en_q;
   col_t             col_q;
   logic [1:0]       row_q;
   logic [23:0]      line1_q [IMG_W];
   logic [23:0]      line2_q [IMG_W];
   logic [2:0][23:0] wcol0_q;
   logic [2:0][23:0] wcol1_q;

   logic             accept;
   logic             xfer;
   logic             produce;
   logic             col_last;
   col_t             cur_col;
   logic [1:0]       cur_row;
   logic [2:0][23:0] new_col;

   // rdy_en_q keeps the input closed while in reset and opens it on the first edge after.
   assign pix_ready_o = rdy_en_q && (win_ready_i || !win_valid_o);
   assign accept      = pix_valid_i && pix_ready_o;
   assign xfer        = win_valid_o && win_ready_i;

   always_comb begin
      cur_col    = sof_i ? '0 : col_q;
      cur_row    = sof_i ? 2'd0 : row_q;
      col_last   = (cur_col == col_t'(IMG_W - 1));
      new_col[0] = line2_q[cur_col];
      new_col[1] = line1_q[cur_col];
      new_col[2] = {r_i, g_i, b_i};
      // row_q saturates at 2, so "row 2" means "at least two full lines above".
      produce    = accept && (cur_row == 2'd2) && (cur_col >= col_t'(2));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdy_en_q <= 1'b0;
         col_q    <= '0;
         row_q    <= 2'd0;
      end else begin
         rdy_en_q <= 1'b1;
         if (accept) begin
            col_q <= col_last ? '0 : cur_col + col_t'(1);
            if (col_last) row_q <= (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
            else          row_q <= cur_row;
         end
      end
   end

   // Line memories are deliberately not reset; the row/col gating on produce
   // keeps stale contents out of any valid window.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         line2_q[cur_col] <= line1_q[cur_col];
         line1_q[cur_col] <= new_col[2];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wcol0_q     <= '0;
         wcol1_q     <= '0;
         win_valid_o <= 1'b0;
         r_o         <= '0;
         g_o         <= '0;
         b_o         <= '0;
      end else begin
         if (accept) begin
            wcol0_q <= wcol1_q;
            wcol1_q <= new_col;
         end
         if (produce) begin
            win_valid_o <= 1'b1;
            for (int x = 0; x < 3; x++) begin
               r_o[x][0] <= wcol0_q[x][23:16];
               r_o[x][1] <= wcol1_q[x][23:16];
               r_o[x][2] <= new_col[x][23:16];
               g_o[x][0] <= wcol0_q[x][15:8];
               g_o[x][1] <= wcol1_q[x][15:8];
               g_o[x][2] <= new_col[x][15:8];
               b_o[x][0] <= wcol0_q[x][7:0];
               b_o[x][1] <= wcol1_q[x][7:0];
               b_o[x][2] <= new_col[x][7:0];
            end
         end else if (xfer) begin
            win_valid_o <= 1'b0;
         end
      end
   end

`ifdef RGB_WIN_ERR_EN
   logic err_q;

   // A new frame arriving mid-line means the previous line was short.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                             err_q <= 1'b0;
      else if (accept && sof_i && col_q != '0) err_q <= 1'b1;
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_window_gen.sv
module tb_rgb_window_gen;
   localparam int W = 4;
`ifdef RGB_WIN_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef logic [2:0][2:0][7:0] win_t;
   typedef struct {
      win_t r;
      win_t g;
      win_t b;
   } wexp_t;
   typedef struct {
      logic       sof;
      logic [7:0] pix;
      logic       exp_valid;
      logic [7:0] exp_r00;
      logic [7:0] exp_r22;
   } vec_t;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       pix_valid_i = 1'b0;
   logic       sof_i = 1'b0;
   logic       win_ready_i = 1'b0;
   logic [7:0] r_i = '0, g_i = '0, b_i = '0;
   logic       pix_ready_o, win_valid_o, err_o;
   win_t       r_o, g_o, b_o;

   rgb_window_gen #(.IMG_W(W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o), .sof_i(sof_i),
      .r_i(r_i), .g_i(g_i), .b_i(b_i),
      .win_valid_o(win_valid_o), .win_ready_i(win_ready_i),
      .r_o(r_o), .g_o(g_o), .b_o(b_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chkw(input string name, input win_t act, input win_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: tracks frame position as plain integers and keeps the
   // last three image lines; windows are read straight out of the image.
   wexp_t       exp_q[$];
   logic [23:0] img [3][W];
   int          m_row = 0, m_col = 0, n_xfer = 0;
   bit          m_valid = 0, m_err = 0, seen = 0, prev_stall = 0;
   bit          er, acc, xf, prod;
   win_t        prev_r;
   wexp_t       w;
   logic [23:0] px;

   always @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) seen <= 1'b0;
      else         seen <= 1'b1;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         exp_q.delete();
         m_row = 0; m_col = 0; m_valid = 0; m_err = 0; prev_stall = 0;
      end else begin
         er = seen && (win_ready_i || !m_valid);
         chk("pix_ready", pix_ready_o, er);
         chk("win_valid", win_valid_o, m_valid);
         chk("err", err_o, ERR_EN ? m_err : 1'b0);
         if (prev_stall) chkw("stall_hold_r", r_o, prev_r);
         xf = m_valid && win_ready_i;
         if (xf) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL xfer_unexpected: got transfer expected none");
            end else begin
               w = exp_q.pop_front();
               chkw("win_r", r_o, w.r);
               chkw("win_g", g_o, w.g);
               chkw("win_b", b_o, w.b);
               n_xfer++;
            end
         end
         prev_stall = m_valid && !win_ready_i;
         prev_r = r_o;
         acc = pix_valid_i && er;
         prod = 0;
         if (acc) begin
            if (sof_i && m_col != 0) m_err = 1;
            if (sof_i) begin m_row = 0; m_col = 0; end
            img[m_row % 3][m_col] = {r_i, g_i, b_i};
            if (m_row >= 2 && m_col >= 2) begin
               prod = 1;
               for (int x = 0; x < 3; x++)
                  for (int y = 0; y < 3; y++) begin
                     px = img[(m_row - 2 + x) % 3][m_col - 2 + y];
                     w.r[x][y] = px[23:16];
                     w.g[x][y] = px[15:8];
                     w.b[x][y] = px[7:0];
                  end
               exp_q.push_back(w);
            end
            m_col++;
            if (m_col == W) begin m_col = 0; m_row++; end
         end
         if (prod)    m_valid = 1;
         else if (xf) m_valid = 0;
      end
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [7:0] p, input logic rdy);
      pix_valid_i = v; sof_i = s; r_i = p; g_i = p ^ 8'h55; b_i = p + 8'd7; win_ready_i = rdy;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      cyc(); cyc();
      rst_ni = 1'b1;
      cyc();
   endtask

   vec_t        vec [16];
   logic [15:0] vmask;
   win_t        saved;
   int          n0, found;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vmask = 16'hCC00;
      for (int i = 0; i < 16; i++) begin
         vec[i].sof       = (i == 0);
         vec[i].pix       = 8'(i);
         vec[i].exp_valid = vmask[i];
         vec[i].exp_r22   = 8'(i);
         vec[i].exp_r00   = 8'(i - 10);
      end

      #12;
      chk("rst_win_valid", win_valid_o, 1'b0);
      chk("rst_pix_ready", pix_ready_o, 1'b0);
      chkw("rst_r", r_o, '0);
      chk("rst_err", err_o, 1'b0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      cyc();
      chk("ready_after_reset", pix_ready_o, 1'b1);

      // 4x4 frame, r=g=b-ish = 4*row+col, consumer always ready
      n0 = n_xfer;
      for (int i = 0; i < 16; i++) begin
         pix_valid_i = 1'b1; sof_i = vec[i].sof; win_ready_i = 1'b1;
         r_i = vec[i].pix; g_i = vec[i].pix; b_i = vec[i].pix;
         cyc();
         chk($sformatf("tbl_valid_%0d", i), win_valid_o, vec[i].exp_valid);
         if (vec[i].exp_valid) begin
            chk($sformatf("tbl_r00_%0d", i), r_o[0][0], vec[i].exp_r00);
            chk($sformatf("tbl_r22_%0d", i), r_o[2][2], vec[i].exp_r22);
         end
      end
      drive(1'b0, 1'b0, 8'd0, 1'b1);
      cyc(); cyc();
      chk("frame_window_count", n_xfer - n0, 4);

      // back-pressure: hold a window for 5 cycles
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, i == 0, 8'(100 + i), 1'b1);
         cyc();
      end
      drive(1'b1, 1'b0, 8'd110, 1'b0);
      cyc();
      chk("stall_valid", win_valid_o, 1'b1);
      saved = r_o;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 8'd99, 1'b0);
         cyc();
         chk("stall_pix_ready", pix_ready_o, 1'b0);
         chkw("stall_r_o", r_o, saved);
      end
      drive(1'b0, 1'b0, 8'd0, 1'b1);
      cyc();
      chk("xfer_clears_valid", win_valid_o, 1'b0);
      chk("ready_after_xfer", pix_ready_o, 1'b1);

      // short line restart, sticky error, first window latency
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, i == 0, 8'(i), 1'b1);
         cyc();
      end
      chk("err_before_short", err_o, 1'b0);
      found = 0;
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, k == 1, 8'(50 + k), 1'b1);
         cyc();
         if (k == 1) chk("err_short_line", err_o, ERR_EN);
         if (win_valid_o) begin
            found = k;
            break;
         end
      end
      chk("first_window_accept_no", found, 11);
      drive(1'b1, 1'b0, 8'd80, 1'b1);
      cyc();
      chk("no_bubble_second", win_valid_o, 1'b1);
      drive(1'b1, 1'b0, 8'd81, 1'b1);
      cyc();
      chk("line_boundary_gap", win_valid_o, 1'b0);
      chk("err_sticky", err_o, ERR_EN);

      // async reset with a pending window
      drive(1'b1, 1'b0, 8'd82, 1'b1);
      cyc();
      drive(1'b1, 1'b0, 8'd83, 1'b0);
      cyc();
      chk("pending_before_reset", win_valid_o, 1'b1);
      #2;
      rst_ni = 1'b0;
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      #1;
      chk("async_rst_valid", win_valid_o, 1'b0);
      chkw("async_rst_r", r_o, '0);
      chk("async_rst_ready", pix_ready_o, 1'b0);
      chk("async_rst_err", err_o, 1'b0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      cyc();

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         pix_valid_i = ($urandom % 4) != 0;
         win_ready_i = ($urandom % 3) != 0;
         sof_i       = ($urandom % 50) == 0;
         r_i = 8'($urandom); g_i = 8'($urandom); b_i = 8'($urandom);
         cyc();
      end
      drive(1'b0, 1'b0, 8'd0, 1'b1);
      cyc(); cyc(); cyc();
      chk("drain_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
